// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for mem_arbiter.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface mem_arbiter_if;
  logic        req0;
  logic        req1;
  logic        wr0;
  logic        wr1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic        gnt0;
  logic        gnt1;
  logic        rvalid0;
  logic        rvalid1;
  logic [7:0]  rdata0;
  logic [7:0]  rdata1;
  logic        mem_wr;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;

  modport slave (
    input  req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_data_out,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_wr, mem_address, mem_data_in
  );

  modport master (
    output req0, req1, wr0, wr1, addr0, addr1, wdata0, wdata1, mem_data_out,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_wr, mem_address, mem_data_in
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with a burst cap, zero-latency grant and
// one-cycle registered read return routed to the issuing port.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 4
) (
  input logic           i_clk,
  input logic           i_nrst,
  mem_arbiter_if.slave  io_bus
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_BURST);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            r_state;
  state_e            w_state_d;
  logic              r_last_owner;
  logic              w_last_owner_d;
  logic [CntW-1:0]   r_burst_cnt;
  logic [CntW-1:0]   w_burst_cnt_d;
  logic [CntW-1:0]   w_burst_inc;
  logic              r_rvalid0;
  logic              r_rvalid1;
  logic              w_gnt0;
  logic              w_gnt1;

  // Under contention the current owner keeps the bus until its burst is used up.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (io_bus.req0 && io_bus.req1) begin
      if (r_state == StOwn0 && r_burst_cnt < MaxCnt) begin
        w_gnt0 = 1'b1;
      end else if (r_state == StOwn1 && r_burst_cnt < MaxCnt) begin
        w_gnt1 = 1'b1;
      end else if (r_last_owner) begin
        w_gnt0 = 1'b1;
      end else begin
        w_gnt1 = 1'b1;
      end
    end else begin
      w_gnt0 = io_bus.req0;
      w_gnt1 = io_bus.req1;
    end
  end

  assign w_burst_inc = (r_burst_cnt == MaxCnt) ? MaxCnt : r_burst_cnt + CntW'(1);

  always_comb begin
    w_state_d      = StIdle;
    w_last_owner_d = r_last_owner;
    w_burst_cnt_d  = '0;
    if (w_gnt0) begin
      w_state_d      = StOwn0;
      w_last_owner_d = 1'b0;
      w_burst_cnt_d  = (r_state == StOwn0) ? w_burst_inc : CntW'(1);
    end else if (w_gnt1) begin
      w_state_d      = StOwn1;
      w_last_owner_d = 1'b1;
      w_burst_cnt_d  = (r_state == StOwn1) ? w_burst_inc : CntW'(1);
    end
  end

  // last_owner resets to 1 so the first contention goes to port 0.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_state      <= StIdle;
      r_last_owner <= 1'b1;
      r_burst_cnt  <= '0;
      r_rvalid0    <= 1'b0;
      r_rvalid1    <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_last_owner <= w_last_owner_d;
      r_burst_cnt  <= w_burst_cnt_d;
      r_rvalid0    <= w_gnt0 & ~io_bus.wr0;
      r_rvalid1    <= w_gnt1 & ~io_bus.wr1;
    end
  end

  always_comb begin
    io_bus.mem_wr      = 1'b0;
    io_bus.mem_address = 16'h0000;
    io_bus.mem_data_in = 8'h00;
    if (w_gnt0) begin
      io_bus.mem_wr      = io_bus.wr0;
      io_bus.mem_address = io_bus.addr0;
      io_bus.mem_data_in = io_bus.wdata0;
    end else if (w_gnt1) begin
      io_bus.mem_wr      = io_bus.wr1;
      io_bus.mem_address = io_bus.addr1;
      io_bus.mem_data_in = io_bus.wdata1;
    end
  end

  assign io_bus.gnt0    = w_gnt0;
  assign io_bus.gnt1    = w_gnt1;
  assign io_bus.rvalid0 = r_rvalid0;
  assign io_bus.rvalid1 = r_rvalid1;
  assign io_bus.rdata0  = r_rvalid0 ? io_bus.mem_data_out : 8'h00;
  assign io_bus.rdata1  = r_rvalid1 ? io_bus.mem_data_out : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a registered-read memory model:
// ROM below 16'h8000, 4 KiB RAM mirrored above it.
module tb_mem_arbiter;

  logic clk;
  logic nrst;
  int   errors;
  int   checks;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_BURST(4)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    if (a == 16'h0000) return 8'h3C;
    if (a == 16'h0001) return 8'h5A;
    return a[7:0] ^ 8'h96;
  endfunction

  logic [7:0] ram [0:4095];

  always @(posedge clk) begin
    if (bus.mem_wr && bus.mem_address >= 16'h8000) ram[bus.mem_address[11:0]] <= bus.mem_data_in;
    bus.mem_data_out <= (bus.mem_address < 16'h8000) ? rom_byte(bus.mem_address)
                                                     : ram[bus.mem_address[11:0]];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  int unsigned burst_exp [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};

  initial begin
    errors      = 0;
    checks      = 0;
    nrst        = 1'b0;
    bus.req0    = 1'b1;
    bus.req1    = 1'b1;
    bus.wr0     = 1'b0;
    bus.wr1     = 1'b0;
    bus.addr0   = 16'h0000;
    bus.addr1   = 16'h0010;
    bus.wdata0  = 8'h00;
    bus.wdata1  = 8'h00;

    // Reset with both ports requesting
    @(negedge clk);
    #1;
    check("rst_rvalid0", bus.rvalid0, 1'b0);
    check("rst_rvalid1", bus.rvalid1, 1'b0);
    check("rst_rdata0", bus.rdata0, 8'h00);
    check("rst_rdata1", bus.rdata1, 8'h00);
    cyc();
    nrst = 1'b1;
    #1;
    check("first_gnt0", bus.gnt0, 1'b1);
    check("first_gnt1", bus.gnt1, 1'b0);
    check("first_addr", bus.mem_address, 16'h0000);
    cyc();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    #1;
    check("rd_rvalid0", bus.rvalid0, 1'b1);
    check("rd_rdata0", bus.rdata0, 8'h3C);
    check("rd_rvalid1", bus.rvalid1, 1'b0);
    check("idle_mem_wr", bus.mem_wr, 1'b0);
    check("idle_mem_addr", bus.mem_address, 16'h0000);
    check("idle_mem_din", bus.mem_data_in, 8'h00);
    cyc();
    check("rd_one_shot", bus.rvalid0, 1'b0);

    // Port 1 writes RAM, port 0 reads it back next cycle
    bus.req1   = 1'b1;
    bus.wr1    = 1'b1;
    bus.addr1  = 16'hF000;
    bus.wdata1 = 8'hA5;
    #1;
    check("wr_gnt1", bus.gnt1, 1'b1);
    check("wr_mem_wr", bus.mem_wr, 1'b1);
    check("wr_mem_addr", bus.mem_address, 16'hF000);
    check("wr_mem_din", bus.mem_data_in, 8'hA5);
    cyc();
    bus.req1  = 1'b0;
    bus.wr1   = 1'b0;
    bus.req0  = 1'b1;
    bus.addr0 = 16'hF000;
    #1;
    check("wr_no_rvalid1", bus.rvalid1, 1'b0);
    check("raw_gnt0", bus.gnt0, 1'b1);
    cyc();
    bus.req0 = 1'b0;
    #1;
    check("raw_rvalid0", bus.rvalid0, 1'b1);
    check("raw_rdata0", bus.rdata0, 8'hA5);
    check("raw_rvalid1", bus.rvalid1, 1'b0);

    // Burst limit under continuous contention, starting from reset
    nrst = 1'b0;
    #1;
    nrst = 1'b1;
    bus.req0  = 1'b1;
    bus.req1  = 1'b1;
    bus.addr0 = 16'h0100;
    bus.addr1 = 16'h0200;
    for (int i = 0; i < 12; i++) begin
      #1;
      check($sformatf("burst_gnt0_%0d", i), bus.gnt0, burst_exp[i] == 0);
      check($sformatf("burst_gnt1_%0d", i), bus.gnt1, burst_exp[i] == 1);
      if (i > 0) begin
        check($sformatf("burst_rv0_%0d", i), bus.rvalid0, burst_exp[i-1] == 0);
        check($sformatf("burst_rv1_%0d", i), bus.rvalid1, burst_exp[i-1] == 1);
      end
      cyc();
    end

    // Single requester keeps the bus; a late second requester is served at once
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    cyc();
    bus.req0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("solo_gnt0_%0d", i), bus.gnt0, 1'b1);
      cyc();
    end
    bus.req1 = 1'b1;
    #1;
    check("yield_gnt1", bus.gnt1, 1'b1);
    check("yield_gnt0", bus.gnt0, 1'b0);
    cyc();

    // Reset during a pending read on port 1
    bus.req0  = 1'b0;
    bus.req1  = 1'b1;
    bus.addr1 = 16'h0001;
    #1;
    check("mid_gnt1", bus.gnt1, 1'b1);
    cyc();
    bus.req1 = 1'b0;
    #1;
    check("mid_rvalid1_pre", bus.rvalid1, 1'b1);
    check("mid_rdata1_pre", bus.rdata1, 8'h5A);
    nrst = 1'b0;
    #1;
    check("mid_rvalid1_rst", bus.rvalid1, 1'b0);
    check("mid_rdata1_rst", bus.rdata1, 8'h00);
    cyc();
    nrst = 1'b1;
    cyc();
    check("post_rvalid0", bus.rvalid0, 1'b0);
    check("post_rvalid1", bus.rvalid1, 1'b0);
    check("post_mem_wr", bus.mem_wr, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter that shares the single-port 8-bit/16-bit-address memory between the CPU core (port 0) and a secondary requester such as a loader or debug port (port 1). It issues at most one memory transaction per cycle and routes read data back to the issuing port one cycle later, matching the memory's registered read. A burst limit caps consecutive grants to one port while the other is waiting, so neither port can starve.

## Interface
- MAX_BURST, 4: max consecutive grants to one port while the other port requests (≥1)
- clk  in  1  system clock, all state updates on rising edge
- nrst  in  1  asynchronous, active-low reset
- req0 / req1  in  1  port requests a transaction this cycle
- wr0 / wr1  in  1  1 = write, 0 = read (valid with req)
- addr0 / addr1  in  16  byte address
- wdata0 / wdata1  in  8  write data
- gnt0 / gnt1  out  1  combinational; transaction accepted and issued this cycle
- rvalid0 / rvalid1  out  1  registered; read data for port valid this cycle
- rdata0 / rdata1  out  8  read data, valid when rvalid set, else 8'h00
- mem_wr  out  1  memory write strobe
- mem_address  out  16  memory address
- mem_data_in  out  8  memory write data
- mem_data_out  in  8  memory registered read data (may be high-Z for unmapped addresses; passed through unchanged)

## Operation
- State register: IDLE (no grant last cycle), OWN0, OWN1 (port granted last cycle). Side registers: last_owner (1 bit), burst_cnt (0..MAX_BURST, saturating), rd_pending0/1.
- Grant decision (combinational, each cycle):
  - no req: no grant.
  - one req: grant that port.
  - both req, state OWNx and burst_cnt < MAX_BURST: grant x.
  - both req, otherwise: grant the port ≠ last_owner.
- At most one of gnt0/gnt1 high; gnt never high without matching req.
- Memory side: when gnt_x, mem_address=addr_x, mem_data_in=wdata_x, mem_wr=wr_x. With no grant: mem_wr=0, mem_address=16'h0000, mem_data_in=8'h00.
- State update on clock:
  - grant to x: state←OWNx, last_owner←x; burst_cnt←(state==OWNx) ? min(burst_cnt+1, MAX_BURST) : 1.
  - no grant: state←IDLE, burst_cnt←0, last_owner unchanged.
- Read return: a granted read (wr_x=0) sets rvalid_x for exactly the next cycle; rdata_x = mem_data_out while rvalid_x, else 8'h00. Granted writes produce no rvalid; gnt is the write acknowledge.
- Back-to-back reads by alternating ports: rvalid follows the issuing port each cycle; rvalid0 and rvalid1 never both high.
- Requester holds req/wr/addr/wdata stable until gnt; may drop req or change fields after the granting edge.

## Timing
- Reset (nrst low, async): state=IDLE, last_owner=1, burst_cnt=0, rvalid0=rvalid1=0; thus rdata0=rdata1=8'h00; memory-side outputs at idle values whenever no req.
- First contention after reset grants port 0.
- Grant latency: 0 cycles (same cycle as req if arbitration won).
- Read latency: 1 cycle from granting edge to rvalid.
- Worst-case wait under continuous contention: MAX_BURST cycles.
- Reset asserted mid-transaction: pending rvalid discarded, no data returned; requester must reissue after reset release. Memory contents are the memory's responsibility.
- Write followed by read to same address (any ports, consecutive cycles): read returns new data (memory write lands on the granting edge).

## Test plan
- Reset: nrst low with req0=req1=1 → after release, gnt0=1 first cycle, gnt1=0; rvalid0/1=0 and rdata0/1=8'h00 during reset.
- Single port read: req0, wr0=0, addr0=16'h0000 (ROM byte 0) → gnt0 same cycle, mem_address=16'h0000; next cycle rvalid0=1, rdata0=ROM[0], rvalid1=0.
- Write/read across ports: port1 writes 8'hA5 to 16'hF000 (RAM with TOP_OF_STACK=16'hFFFF); next cycle port0 reads 16'hF000 → rvalid0 one cycle later with rdata0=8'hA5.
- Burst limit: MAX_BURST=4, req0 and req1 held continuously → grant pattern 0,0,0,0,1,1,1,1,0,… ; gnt never simultaneous.
- Yield when idle: req0 only for 10 cycles → gnt0 all 10 cycles (burst_cnt saturates at 4); req1 raised at cycle 10 → gnt1 granted at cycle 10.
- Reset mid-read: grant read to port 1, assert nrst the following cycle → rvalid1=0 immediately; after release, state=IDLE, no stale rvalid.
